// File: rtl/ccff_chain_loader.sv
// Far-end driver for a tile configuration chain: serializes bitstream words into
// ccff_head (LOAD) or measures chain length with a single-marker probe (PROBE).
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 5,
  parameter int WORD_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clock,
  input  logic              global_reset_n,
  input  logic              cmd_load,
  input  logic              cmd_probe,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  probe_len,
  output logic              len_ok
);

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] SEEK_MAX = CNT_W'(2 * CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(WORD_W);
  localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_WAIT, S_LD_SHIFT, S_FLUSH, S_MARK, S_SEEK, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              config_enable_q, config_enable_d;
  logic              ccff_head_q, ccff_head_d;
  logic              last_q, last_d;
  logic              len_ok_q, len_ok_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  probe_len_q, probe_len_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic [WORD_W-1:0] sh_q, sh_d, sh_shift;

  assign sh_shift = sh_q << 1;

  // cnt_q is bits-left during LOAD, flush-cycles-left in FLUSH, marker distance in SEEK.
  // config_enable/ccff_head are registered, so they are computed for the state being entered.
  always_comb begin
    state_d         = state_q;
    config_enable_d = 1'b0;
    ccff_head_d     = 1'b0;
    cnt_d           = cnt_q;
    wbits_d         = wbits_q;
    sh_d            = sh_q;
    last_d          = last_q;
    err_code_d      = err_code_q;
    probe_len_d     = probe_len_q;
    len_ok_d        = len_ok_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_load) begin
          state_d    = S_LD_WAIT;
          err_code_d = 2'd0;
          cnt_d      = LEN_C;
        end else if (cmd_probe) begin
          state_d         = S_FLUSH;
          err_code_d      = 2'd0;
          cnt_d           = LEN_C;
          config_enable_d = 1'b1;
        end
      end
      S_LD_WAIT: begin
        if (s_valid) begin
          state_d         = S_LD_SHIFT;
          sh_d            = s_data;
          wbits_d         = WB_FULL;
          last_d          = s_last;
          config_enable_d = 1'b1;
          ccff_head_d     = s_data[WORD_W-1];
        end
      end
      S_LD_SHIFT: begin
        sh_d    = sh_shift;
        wbits_d = wbits_q - WB_ONE;
        cnt_d   = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = S_DONE;
          if (!last_q) err_code_d = 2'd2;
        end else if (wbits_q == WB_ONE) begin
          if (last_q) begin
            state_d    = S_DONE;
            err_code_d = 2'd1;
          end else begin
            state_d = S_LD_WAIT;
          end
        end else begin
          config_enable_d = 1'b1;
          ccff_head_d     = sh_shift[WORD_W-1];
        end
      end
      S_FLUSH: begin
        config_enable_d = 1'b1;
        if (cnt_q == ONE_C) begin
          state_d     = S_MARK;
          ccff_head_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_MARK: begin
        state_d         = S_SEEK;
        cnt_d           = ONE_C;
        config_enable_d = 1'b1;
      end
      S_SEEK: begin
        if (ccff_tail) begin
          state_d     = S_DONE;
          probe_len_d = cnt_q;
          len_ok_d    = (cnt_q == LEN_C);
        end else if (cnt_q == SEEK_MAX) begin
          state_d     = S_DONE;
          probe_len_d = '0;
          len_ok_d    = 1'b0;
          err_code_d  = 2'd3;
        end else begin
          cnt_d           = cnt_q + ONE_C;
          config_enable_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q         <= S_IDLE;
      config_enable_q <= 1'b0;
      ccff_head_q     <= 1'b0;
      cnt_q           <= '0;
      wbits_q         <= '0;
      last_q          <= 1'b0;
      err_code_q      <= 2'd0;
      probe_len_q     <= '0;
      len_ok_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      config_enable_q <= config_enable_d;
      ccff_head_q     <= ccff_head_d;
      cnt_q           <= cnt_d;
      wbits_q         <= wbits_d;
      last_q          <= last_d;
      err_code_q      <= err_code_d;
      probe_len_q     <= probe_len_d;
      len_ok_q        <= len_ok_d;
    end
  end

  // Word shifter is pure datapath; its contents are only meaningful after a capture.
  always_ff @(posedge prog_clock) begin
    sh_q <= sh_d;
  end

  assign s_ready       = (state_q == S_LD_WAIT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign config_enable = config_enable_q;
  assign ccff_head     = ccff_head_q;
  assign err_code      = err_code_q;
  assign probe_len     = probe_len_q;
  assign len_ok        = len_ok_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: behavioural chain model plus a
// stream-level reference for LOAD and a shift-timeline reference for PROBE.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 5;
  localparam int WORD_W    = 4;
  localparam int CNT_W     = 16;

  logic              prog_clock = 1'b0;
  logic              global_reset_n;
  logic              cmd_load, cmd_probe, s_valid, s_ready, s_last;
  logic [WORD_W-1:0] s_data;
  logic              config_enable, ccff_head, ccff_tail;
  logic              busy, done, len_ok;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  probe_len;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] chain_q;
  logic [15:0] pre_val = '0;
  int          model_len = 5;
  bit          tie0 = 1'b0;
  bit          preload = 1'b0;
  bit          mon_bits[$];
  int          done_cnt = 0;

  logic [WORD_W-1:0] wd [8];
  bit                wl [8];
  int                st [8];
  bit                noise = 1'b0;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .prog_clock(prog_clock), .global_reset_n(global_reset_n),
    .cmd_load(cmd_load), .cmd_probe(cmd_probe),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .config_enable(config_enable), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .err_code(err_code),
    .probe_len(probe_len), .len_ok(len_ok)
  );

  always #5 prog_clock = ~prog_clock;

  // Target chain: shifts on enabled rising edges, newest bit at chain_q[0].
  always @(posedge prog_clock) begin
    if (preload) chain_q <= pre_val;
    else if (config_enable) chain_q <= {chain_q[14:0], ccff_head};
  end
  assign ccff_tail = tie0 ? 1'b0 : chain_q[model_len-1];

  always @(negedge prog_clock) begin
    if (config_enable === 1'b1) mon_bits.push_back(ccff_head);
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input int n, input string tag, input bit also_probe);
    int exp_n, exp_err, exp_acc, i0, d0, k, gap, guard, post;
    logic [31:0] exp_v, got_v, mask;
    bit hs, fin;
    exp_n = 0; exp_err = 0; exp_acc = 0; exp_v = 0;
    for (int w = 0; w < n; w++) begin
      exp_acc++;
      for (int b = WORD_W - 1; b >= 0; b--)
        if (exp_n < CHAIN_LEN) begin
          exp_v = {exp_v[30:0], wd[w][b]};
          exp_n++;
        end
      if (exp_n == CHAIN_LEN) begin exp_err = wl[w] ? 0 : 2; break; end
      if (wl[w]) begin exp_err = 1; break; end
    end
    model_len = CHAIN_LEN; tie0 = 1'b0;
    i0 = mon_bits.size(); d0 = done_cnt;
    @(posedge prog_clock); #2;
    cmd_load = 1'b1; cmd_probe = also_probe;
    @(posedge prog_clock); #2;
    cmd_load = 1'b0; cmd_probe = 1'b0;
    k = 0; gap = st[0]; fin = 1'b0; guard = 0; post = 0;
    while (guard < 200 && post < 4) begin
      s_valid = (k < n && gap == 0);
      if (k < n) begin s_data = wd[k]; s_last = wl[k]; end
      cmd_probe = noise && !fin && ($urandom_range(0, 3) == 0);
      @(negedge prog_clock);
      hs = s_valid && s_ready;
      if (done) fin = 1'b1;
      @(posedge prog_clock); #2;
      guard++;
      if (fin) post++;
      if (hs) begin k++; if (k < n) gap = st[k]; end
      else if (!s_valid && gap > 0) gap--;
    end
    s_valid = 1'b0; cmd_probe = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    got_v = 0;
    for (int i = i0; i < mon_bits.size(); i++) got_v = {got_v[30:0], mon_bits[i]};
    mask = (32'h1 << exp_n) - 32'h1;
    chk({tag, "_nshift"}, mon_bits.size() - i0, exp_n);
    chk({tag, "_headseq"}, got_v, exp_v);
    chk({tag, "_chain"}, {16'h0, chain_q} & mask, exp_v);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_err"}, err_code, exp_err);
    chk({tag, "_acc"}, k, exp_acc);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_probe(input int len, input bit tz, input logic [15:0] pre, input string tag);
    int exp_len, exp_shifts, t, i0, d0, guard, post, ones, pos;
    bit tb, fin;
    exp_len = 0;
    for (int c = 1; c <= 2 * CHAIN_LEN; c++) begin
      t = CHAIN_LEN + 1 + c;
      tb = (t <= len) ? pre[len - t] : (t - len == CHAIN_LEN + 1);
      if (tb && !tz) begin exp_len = c; break; end
    end
    exp_shifts = CHAIN_LEN + 1 + ((exp_len != 0) ? exp_len : 2 * CHAIN_LEN);
    model_len = len; tie0 = tz; pre_val = pre;
    @(posedge prog_clock); #2; preload = 1'b1;
    @(posedge prog_clock); #2; preload = 1'b0;
    i0 = mon_bits.size(); d0 = done_cnt;
    cmd_probe = 1'b1;
    @(posedge prog_clock); #2; cmd_probe = 1'b0;
    fin = 1'b0; guard = 0; post = 0;
    while (guard < 200 && post < 2) begin
      @(negedge prog_clock);
      if (done) fin = 1'b1;
      @(posedge prog_clock); #2;
      guard++;
      if (fin) post++;
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    ones = 0; pos = -1;
    for (int i = i0; i < mon_bits.size(); i++)
      if (mon_bits[i]) begin ones++; if (pos < 0) pos = i - i0; end
    chk({tag, "_len"}, probe_len, exp_len);
    chk({tag, "_lenok"}, len_ok, exp_len == CHAIN_LEN);
    chk({tag, "_err"}, err_code, (exp_len != 0) ? 0 : 3);
    chk({tag, "_nshift"}, mon_bits.size() - i0, exp_shifts);
    chk({tag, "_marker"}, pos, CHAIN_LEN);
    chk({tag, "_ones"}, ones, 1);
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    global_reset_n = 1'b0;
    cmd_load = 0; cmd_probe = 0; s_valid = 0; s_last = 0; s_data = '0;
    preload = 1'b1;
    repeat (2) @(posedge prog_clock);
    #2; preload = 1'b0;
    chk("rst_cen", config_enable, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_plen", probe_len, 0);
    chk("rst_lenok", len_ok, 0);
    global_reset_n = 1'b1;

    wd[0] = 4'hB; wl[0] = 0; st[0] = 0;
    wd[1] = 4'h8; wl[1] = 1; st[1] = 0;
    run_load(2, "ld_basic", 1'b0);
    st[1] = 3;
    run_load(2, "ld_stall", 1'b0);
    st[1] = 0; wl[0] = 1;
    run_load(2, "ld_short", 1'b0);
    wl[0] = 0; wl[1] = 0; wd[2] = 4'h5; wl[2] = 1; st[2] = 0;
    run_load(3, "ld_nolast", 1'b0);
    chk("ld_nolast_ready", s_ready, 0);

    run_probe(5, 1'b0, 16'hFFFF, "pr_5");
    run_probe(4, 1'b0, 16'hFFFF, "pr_4");
    run_probe(5, 1'b1, 16'hFFFF, "pr_tie0");

    // Abort a load mid-shift with an asynchronous reset.
    model_len = CHAIN_LEN; tie0 = 1'b0;
    @(posedge prog_clock); #2; cmd_load = 1'b1;
    @(posedge prog_clock); #2; cmd_load = 1'b0;
    s_valid = 1'b1; s_data = 4'hB; s_last = 1'b0;
    @(posedge prog_clock); #2; s_valid = 1'b0;
    @(posedge prog_clock); #3;
    chk("rstmid_cen_before", config_enable, 1);
    d0 = done_cnt;
    global_reset_n = 1'b0;
    #1;
    chk("rstmid_cen", config_enable, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", s_ready, 0);
    repeat (3) @(posedge prog_clock);
    #2; global_reset_n = 1'b1;
    repeat (3) @(posedge prog_clock);
    #2;
    chk("rstmid_nodone", done_cnt - d0, 0);
    wd[0] = 4'hB; wl[0] = 0; st[0] = 0;
    wd[1] = 4'h8; wl[1] = 1; st[1] = 0;
    run_load(2, "ld_after_rst", 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int w = 0; w < n; w++) begin
          wd[w] = WORD_W'($urandom);
          wl[w] = ($urandom_range(0, 2) == 0);
          st[w] = $urandom_range(0, 3);
        end
        if (n * WORD_W < CHAIN_LEN) wl[n-1] = 1'b1;
        noise = $urandom_range(0, 1);
        run_load(n, "rnd_ld", $urandom_range(0, 1) == 1);
        noise = 1'b0;
      end else begin
        run_probe($urandom_range(1, 12), $urandom_range(0, 5) == 0, 16'($urandom), "rnd_pr");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
